// File: rtl/processor_multicycle.sv
// Multi-cycle RV32I-subset core: unified word memory, 32x32 register file and one shared
// ALU sequenced by a control FSM. A 4-bit LED register is mapped at LED_ADDR.
module processor_multicycle #(
  parameter int          MEM_WORDS = 64,
  parameter string       MEM_FILE  = "memfile.hex",
  parameter logic [31:0] LED_ADDR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] PC1,
  output logic [31:0] Result,
  output logic [3:0]  led
);

  localparam int AW = $clog2(MEM_WORDS);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q, old_pc_q, ir_q, a_q, b_q, aluout_q, data_q, result_q;
  logic [3:0]  led_q;
  logic [31:0] regs_q [32];
  logic [31:0] mem_q  [MEM_WORDS];

  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic [4:0]    rs1, rs2, rd;
  logic [31:0]   imm_i, imm_s, imm_b, imm_j, imm_bj, imm_mem;
  logic [31:0]   alu_b_d, alu_y_d;
  logic          is_sub;
  logic [AW-1:0] pc_idx, alu_idx;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign rd     = ir_q[11:7];

  assign imm_i   = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s   = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b   = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_j   = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
  assign imm_bj  = (opcode == OP_JAL) ? imm_j : imm_b;
  assign imm_mem = (opcode == OP_SW) ? imm_s : imm_i;

  // Word addressing: byte-offset bits are dropped and the index wraps with the memory size.
  assign pc_idx  = pc_q[AW+1:2];
  assign alu_idx = aluout_q[AW+1:2];

  assign is_sub  = (opcode == OP_R) && (funct3 == 3'b000) && ir_q[30];
  assign alu_b_d = (state_q == S_EXECI) ? imm_i : b_q;

  always_comb begin
    alu_y_d = a_q + alu_b_d;
    case (funct3)
      3'b000:  alu_y_d = is_sub ? (a_q - b_q) : (a_q + alu_b_d);
      3'b010:  alu_y_d = {31'b0, ($signed(a_q) < $signed(alu_b_d))};
      3'b110:  alu_y_d = a_q | alu_b_d;
      3'b111:  alu_y_d = a_q & alu_b_d;
      default: alu_y_d = a_q + alu_b_d;
    endcase
  end

  // Memory holds no reset; a store can only fire from MEMWRITE, which reset leaves at once.
  always_ff @(posedge clk) begin
    if (state_q == S_MEMWRITE && aluout_q != LED_ADDR) begin
      mem_q[alu_idx] <= b_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      old_pc_q <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      data_q   <= '0;
      result_q <= '0;
      led_q    <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          ir_q     <= mem_q[pc_idx];
          old_pc_q <= pc_q;
          pc_q     <= pc_q + 32'd4;
          state_q  <= S_DECODE;
        end
        S_DECODE: begin
          a_q      <= regs_q[rs1];
          b_q      <= regs_q[rs2];
          aluout_q <= old_pc_q + imm_bj;
          case (opcode)
            OP_LW, OP_SW: state_q <= S_MEMADR;
            OP_R:         state_q <= S_EXECR;
            OP_I:         state_q <= S_EXECI;
            OP_BR:        state_q <= (funct3 == 3'b000) ? S_BEQ : S_FETCH;
            OP_JAL:       state_q <= S_JAL;
            default:      state_q <= S_FETCH;
          endcase
        end
        S_MEMADR: begin
          aluout_q <= a_q + imm_mem;
          state_q  <= (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        end
        S_MEMREAD: begin
          data_q  <= (aluout_q == LED_ADDR) ? {28'b0, led_q} : mem_q[alu_idx];
          state_q <= S_MEMWB;
        end
        S_MEMWB: begin
          if (rd != 5'd0) begin
            regs_q[rd] <= data_q;
            result_q   <= data_q;
          end
          state_q <= S_FETCH;
        end
        S_MEMWRITE: begin
          if (aluout_q == LED_ADDR) led_q <= b_q[3:0];
          state_q <= S_FETCH;
        end
        S_EXECR, S_EXECI: begin
          aluout_q <= alu_y_d;
          state_q  <= S_ALUWB;
        end
        S_ALUWB: begin
          if (rd != 5'd0) begin
            regs_q[rd] <= aluout_q;
            result_q   <= aluout_q;
          end
          state_q <= S_FETCH;
        end
        S_BEQ: begin
          if (a_q == b_q) pc_q <= aluout_q;
          state_q <= S_FETCH;
        end
        S_JAL: begin
          pc_q     <= aluout_q;
          aluout_q <= old_pc_q + 32'd4;
          state_q  <= S_ALUWB;
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign PC1    = pc_q;
  assign Result = result_q;
  assign led    = led_q;

endmodule

// File: tb/tb_processor_multicycle.sv
// Bench for processor_multicycle: preloads a program, queues the expected per-instruction
// outcome (cycles, PC, Result, LED) and compares each as the core retires it.
module tb_processor_multicycle;

  localparam logic [31:0] OP_I  = 32'h13;
  localparam logic [31:0] OP_LW = 32'h03;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC1;
  logic [31:0] Result;
  logic [3:0]  led;

  int checks = 0;
  int errors = 0;
  int load_idx = 0;

  typedef struct {
    string       tag;
    int          cycles;
    logic [31:0] pc;
    logic [31:0] res;
    logic [3:0]  led;
  } exp_t;

  exp_t sb_q[$];

  processor_multicycle #(
    .MEM_WORDS(64),
    .LED_ADDR (32'h0000_0100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .PC1   (PC1),
    .Result(Result),
    .led   (led)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [31:0] f7, input logic [31:0] rs2,
                                        input logic [31:0] rs1, input logic [31:0] f3,
                                        input logic [31:0] rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [31:0] rs1,
                                        input logic [31:0] f3, input logic [31:0] rd,
                                        input logic [31:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction

  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [31:0] rs2,
                                        input logic [31:0] rs1);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [31:0] rs2,
                                        input logic [31:0] rs1);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [31:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction

  // Place one instruction; cycles == 0 marks an instruction the program jumps over.
  task automatic put(input logic [31:0] instr, input string tag, input int cycles,
                     input logic [31:0] pc, input logic [31:0] res, input logic [3:0] ld);
    exp_t e;
    dut.mem_q[load_idx] <= instr;
    load_idx++;
    if (cycles > 0) begin
      e.tag    = tag;
      e.cycles = cycles;
      e.pc     = pc;
      e.res    = res;
      e.led    = ld;
      sb_q.push_back(e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        e;
    logic [31:0] prev_res;
    int          first;

    reset = 1'b0;
    put(enc_i(5, 0, 0, 1, OP_I),        "addi_x1",   4, 32'h04, 32'd5,  4'h0);
    put(enc_i(12, 0, 0, 2, OP_I),       "addi_x2",   4, 32'h08, 32'd12, 4'h0);
    put(enc_r(0, 2, 1, 0, 3),           "add",       4, 32'h0C, 32'd17, 4'h0);
    put(enc_r(32'h20, 1, 2, 0, 4),      "sub",       4, 32'h10, 32'd7,  4'h0);
    put(enc_r(0, 2, 1, 2, 5),           "slt",       4, 32'h14, 32'd1,  4'h0);
    put(enc_i(32'h40, 0, 0, 6, OP_I),   "addi_x6",   4, 32'h18, 32'h40, 4'h0);
    put(enc_s(0, 3, 6),                 "sw_mem",    4, 32'h1C, 32'h40, 4'h0);
    put(enc_i(0, 6, 2, 7, OP_LW),       "lw_mem",    5, 32'h20, 32'd17, 4'h0);
    put(enc_b(8, 1, 1),                 "beq_taken", 3, 32'h28, 32'd17, 4'h0);
    put(enc_i(99, 0, 0, 10, OP_I),      "skip0",     0, 32'h0,  32'h0,  4'h0);
    put(enc_b(8, 2, 1),                 "beq_nt",    3, 32'h2C, 32'd17, 4'h0);
    put(enc_i(7, 0, 0, 0, OP_I),        "addi_x0",   4, 32'h30, 32'd17, 4'h0);
    put(enc_j(12, 1),                   "jal",       4, 32'h3C, 32'h34, 4'h0);
    put(enc_i(99, 0, 0, 10, OP_I),      "skip1",     0, 32'h0,  32'h0,  4'h0);
    put(enc_i(99, 0, 0, 10, OP_I),      "skip2",     0, 32'h0,  32'h0,  4'h0);
    put(enc_r(0, 2, 0, 0, 11),          "add_x0",    4, 32'h40, 32'd12, 4'h0);
    // Word 0x40 is overwritten by sw_mem with 17, an undefined opcode, before it runs.
    put(enc_i(99, 0, 0, 10, OP_I),      "undef",     2, 32'h44, 32'd12, 4'h0);
    put(enc_i(32'h100, 0, 0, 8, OP_I),  "addi_x8",   4, 32'h48, 32'h100, 4'h0);
    put(enc_i(32'h1A, 0, 0, 9, OP_I),   "addi_x9",   4, 32'h4C, 32'h1A, 4'h0);
    put(enc_s(0, 9, 8),                 "sw_led",    4, 32'h50, 32'h1A, 4'hA);
    put(enc_i(0, 8, 2, 12, OP_LW),      "lw_led",    5, 32'h54, 32'h0A, 4'hA);
    put(enc_i(-3, 0, 0, 14, OP_I),      "addi_neg",  4, 32'h58, 32'hFFFF_FFFD, 4'hA);
    put(enc_i(5, 14, 2, 13, OP_I),      "slti",      4, 32'h5C, 32'd1,  4'hA);
    put(enc_i(32'hF0, 14, 7, 15, OP_I), "andi",      4, 32'h60, 32'hF0, 4'hA);
    put(enc_i(3, 1, 6, 16, OP_I),       "ori",       4, 32'h64, 32'h37, 4'hA);
    put(enc_r(0, 2, 1, 6, 17),          "or",        4, 32'h68, 32'h3C, 4'hA);
    put(enc_r(0, 4, 3, 7, 18),          "and",       4, 32'h6C, 32'd1,  4'hA);
    put(enc_i(0, 0, 2, 19, OP_LW),      "lw_word0",  5, 32'h70, 32'h0050_0093, 4'hA);
    put(enc_b(0, 0, 0),                 "beq_self",  3, 32'h70, 32'h0050_0093, 4'hA);
    sb_q.push_back(sb_q[sb_q.size() - 1]);

    tick(2);
    check_val("rst_pc", PC1, 32'h0);
    check_val("rst_result", Result, 32'h0);
    check_val("rst_led", {28'b0, led}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick(1);
    check_val("first_fetch_pc", PC1, 32'h4);

    prev_res = 32'h0;
    first    = 1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      tick(e.cycles - 1 - first);
      check_val({e.tag, "_hold"}, Result, prev_res);
      tick(1);
      check_val({e.tag, "_pc"}, PC1, e.pc);
      check_val({e.tag, "_result"}, Result, e.res);
      check_val({e.tag, "_led"}, {28'b0, led}, {28'b0, e.led});
      $display("txn %-10s pc=%h result=%h led=%h", e.tag, PC1, Result, led);
      prev_res = e.res;
      first    = 0;
    end

    // Asynchronous reset in the middle of an instruction takes effect without a clock edge.
    tick(2);
    #3 reset = 1'b0;
    #2;
    check_val("async_rst_pc", PC1, 32'h0);
    check_val("async_rst_result", Result, 32'h0);
    check_val("async_rst_led", {28'b0, led}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick(1);
    check_val("restart_pc", PC1, 32'h4);
    tick(3);
    check_val("restart_result", Result, 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
